// File: rtl/axil_reg_slave.sv
// axil_reg_slave: AXI4-Lite responder for a bank of NUM_REGS 32-bit registers.
// Reg 0 is a read-only ID.
// Optional macro AXIL_ERR_RESP_EN: SLVERR for out-of-range accesses and writes to reg 0.
// Ports:
//   clk, rstn          clock and synchronous active-low reset
//   aw*/w*/b*          write address, data and response channels (full-word writes)
//   ar*/r*             read address and data channels
//   reg_out            flat register contents, reg i at [32*i +: 32]
//   wr_strobe          one-cycle pulse on the cycle reg i takes a new value
module axil_reg_slave #(
  parameter int          NUM_REGS  = 16,
  parameter logic [31:0] ADDR_BASE = 32'h0000_0000,
  parameter logic [31:0] ID_VALUE  = 32'hC0DE_0001
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     awvalid,
  input  logic [31:0]              awaddr,
  output logic                     awready,
  input  logic                     wvalid,
  input  logic [31:0]              wdata,
  output logic                     wready,
  output logic                     bvalid,
  output logic [1:0]               bresp,
  input  logic                     bready,
  input  logic                     arvalid,
  input  logic [31:0]              araddr,
  output logic                     arready,
  output logic                     rvalid,
  output logic [31:0]              rdata,
  output logic [1:0]               rresp,
  input  logic                     rready,
  output logic [NUM_REGS*32-1:0]   reg_out,
  output logic [NUM_REGS-1:0]      wr_strobe
);
  localparam int          IW   = $clog2(NUM_REGS);
  localparam logic [31:0] SPAN = 32'(4 * NUM_REGS);
  typedef enum logic {W_IDLE, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;
  w_state_t          r_wst;
  r_state_t          r_rst;
  logic [31:0]       r_regs [NUM_REGS];
  logic [31:0]       r_awaddr, r_wdata, r_rdata;
  logic              r_aw_held, r_w_held, r_awready, r_wready, r_bvalid, r_arready, r_rvalid;
  logic [1:0]        r_bresp, r_rresp;
  logic [NUM_REGS-1:0] r_strobe;
  logic              w_aw_hs, w_w_hs, w_ar_hs, w_commit, w_win, w_rin, w_wen;
  logic [31:0]       w_waddr, w_wd, w_woff, w_roff;
  logic [IW-1:0]     w_widx, w_ridx;
  logic [1:0]        w_bresp, w_rresp;
  assign w_aw_hs  = awvalid & r_awready;
  assign w_w_hs   = wvalid & r_wready;
  assign w_ar_hs  = arvalid & r_arready;
  // A beat handshaking this edge is used directly so the commit lands on the second handshake edge
  assign w_waddr  = w_aw_hs ? awaddr : r_awaddr;
  assign w_wd     = w_w_hs ? wdata : r_wdata;
  assign w_woff   = w_waddr - ADDR_BASE;
  assign w_roff   = araddr - ADDR_BASE;
  assign w_widx   = w_woff[2 +: IW];
  assign w_ridx   = w_roff[2 +: IW];
  // Unsigned compare also rejects addresses below ADDR_BASE (they wrap to large offsets)
  assign w_win    = w_woff < SPAN;
  assign w_rin    = w_roff < SPAN;
  assign w_commit = (r_wst == W_IDLE) && (r_aw_held | w_aw_hs) && (r_w_held | w_w_hs);
  assign w_wen    = w_win && (w_widx != '0);
`ifdef AXIL_ERR_RESP_EN
  assign w_bresp  = w_wen ? 2'b00 : 2'b10;
  assign w_rresp  = w_rin ? 2'b00 : 2'b10;
`else
  assign w_bresp  = 2'b00;
  assign w_rresp  = 2'b00;
`endif
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_wst     <= W_IDLE;
      r_aw_held <= 1'b0;
      r_w_held  <= 1'b0;
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bresp   <= 2'b00;
      r_awaddr  <= '0;
      r_wdata   <= '0;
      r_strobe  <= '0;
      r_regs[0] <= ID_VALUE;
      for (int i = 1; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else begin
      r_strobe <= '0;
      if (r_wst == W_IDLE) begin
        if (w_aw_hs) begin
          r_awaddr  <= awaddr;
          r_aw_held <= 1'b1;
        end
        if (w_w_hs) begin
          r_wdata  <= wdata;
          r_w_held <= 1'b1;
        end
        r_awready <= !(r_aw_held | w_aw_hs);
        r_wready  <= !(r_w_held | w_w_hs);
        if (w_commit) begin
          r_wst   <= W_RESP;
          r_bresp <= w_bresp;
          if (w_wen) begin
            r_regs[w_widx]   <= w_wd;
            r_strobe[w_widx] <= 1'b1;
          end
        end
      end else if (!r_bvalid) begin
        r_bvalid <= 1'b1;
      end else if (bready) begin
        r_bvalid  <= 1'b0;
        r_aw_held <= 1'b0;
        r_w_held  <= 1'b0;
        r_awready <= 1'b1;
        r_wready  <= 1'b1;
        r_wst     <= W_IDLE;
      end
    end
  end
  // Read capture samples r_regs before any same-edge write lands
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_rst     <= R_IDLE;
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rdata   <= '0;
      r_rresp   <= 2'b00;
    end else if (r_rst == R_IDLE) begin
      r_arready <= 1'b1;
      if (w_ar_hs) begin
        r_arready <= 1'b0;
        r_rvalid  <= 1'b1;
        r_rdata   <= w_rin ? r_regs[w_ridx] : '0;
        r_rresp   <= w_rresp;
        r_rst     <= R_DATA;
      end
    end else if (rready) begin
      r_rvalid  <= 1'b0;
      r_arready <= 1'b1;
      r_rst     <= R_IDLE;
    end
  end
  assign awready   = r_awready;
  assign wready    = r_wready;
  assign bvalid    = r_bvalid;
  assign bresp     = r_bresp;
  assign arready   = r_arready;
  assign rvalid    = r_rvalid;
  assign rdata     = r_rdata;
  assign rresp     = r_rresp;
  assign wr_strobe = r_strobe;
  for (genvar i = 0; i < NUM_REGS; i++) begin : g_out
    assign reg_out[32*i +: 32] = r_regs[i];
  end
endmodule

// File: tb/tb_axil_reg_slave.sv
// tb_axil_reg_slave: randomized self-checking bench for axil_reg_slave against a register-array model
module tb_axil_reg_slave;
  localparam int          N    = 16;
  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam logic [31:0] ID   = 32'hC0DE_0001;
`ifdef AXIL_ERR_RESP_EN
  localparam bit ERR = 1'b1;
`else
  localparam bit ERR = 1'b0;
`endif
  logic clk = 1'b0, rstn = 1'b0;
  logic awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
  logic [31:0] awaddr = '0, wdata = '0, araddr = '0;
  logic awready, wready, bvalid, arready, rvalid;
  logic [1:0] bresp, rresp;
  logic [31:0] rdata;
  logic [N*32-1:0] reg_out;
  logic [N-1:0] wr_strobe;
  int checks = 0, errors = 0;
  logic [31:0] model [N];
  always #5 clk = ~clk;
  axil_reg_slave dut (
    .clk(clk), .rstn(rstn),
    .awvalid(awvalid), .awaddr(awaddr), .awready(awready),
    .wvalid(wvalid), .wdata(wdata), .wready(wready),
    .bvalid(bvalid), .bresp(bresp), .bready(bready),
    .arvalid(arvalid), .araddr(araddr), .arready(arready),
    .rvalid(rvalid), .rdata(rdata), .rresp(rresp), .rready(rready),
    .reg_out(reg_out), .wr_strobe(wr_strobe)
  );
  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  function automatic bit in_rng(input logic [31:0] a);
    logic [31:0] o = a - BASE;
    return o < 32'(4 * N);
  endfunction
  function automatic int idx_of(input logic [31:0] a);
    logic [31:0] o = a - BASE;
    return int'(o >> 2);
  endfunction
  function automatic logic [N*32-1:0] model_vec();
    logic [N*32-1:0] v;
    for (int i = 0; i < N; i++) v[32*i +: 32] = model[i];
    return v;
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic clear_model();
    model[0] = ID;
    for (int i = 1; i < N; i++) model[i] = '0;
  endtask
  task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input int aw_start, input int w_start, input int bhold);
    int cyc = 0;
    bit aw_done = 0, w_done = 0, aw_fire, w_fire;
    bit ok = in_rng(a) && idx_of(a) != 0;
    logic [N-1:0] exp_strb = ok ? (N'(1) << idx_of(a)) : '0;
    logic [1:0] exp_resp = (ERR && !ok) ? 2'b10 : 2'b00;
    while (!(aw_done && w_done)) begin
      if (cyc >= 50) begin
        checks++; errors++;
        $display("FAIL write_timeout addr=%h: handshake not completed within 50 cycles", a);
        awvalid = 0; wvalid = 0;
        return;
      end
      awvalid = !aw_done && cyc >= aw_start; awaddr = a;
      wvalid = !w_done && cyc >= w_start; wdata = d;
      aw_fire = awvalid && awready;
      w_fire = wvalid && wready;
      tick(); cyc++;
      aw_done |= aw_fire; w_done |= w_fire;
      if (w_done && !aw_done) begin
        checks++;
        if (wready !== 1'b0) begin errors++; $display("FAIL wready_drop: got %b expected 0", wready); end
      end
      if (aw_done && !w_done) begin
        checks++;
        if (awready !== 1'b0) begin errors++; $display("FAIL awready_drop: got %b expected 0", awready); end
      end
    end
    awvalid = 0; wvalid = 0;
    checks++;
    if (wr_strobe !== exp_strb) begin errors++; $display("FAIL strobe addr=%h: got %h expected %h", a, wr_strobe, exp_strb); end
    checks++;
    if (bvalid !== 1'b0) begin errors++; $display("FAIL bvalid_early: got %b expected 0", bvalid); end
    if (ok) model[idx_of(a)] = d;
    tick();
    checks++;
    if (wr_strobe !== '0) begin errors++; $display("FAIL strobe_width: got %h expected 0", wr_strobe); end
    checks++;
    if (bvalid !== 1'b1 || bresp !== exp_resp) begin errors++; $display("FAIL bresp addr=%h: got valid=%b resp=%b expected valid=1 resp=%b", a, bvalid, bresp, exp_resp); end
    for (int i = 0; i < bhold; i++) begin
      tick();
      checks++;
      if (bvalid !== 1'b1 || bresp !== exp_resp || awready !== 1'b0 || wready !== 1'b0) begin
        errors++; $display("FAIL b_hold: got bvalid=%b bresp=%b awready=%b wready=%b expected 1 %b 0 0", bvalid, bresp, awready, wready, exp_resp);
      end
    end
    bready = 1; tick(); bready = 0;
    checks++;
    if (bvalid !== 1'b0) begin errors++; $display("FAIL bvalid_clear: got %b expected 0", bvalid); end
    checks++;
    if (reg_out !== model_vec()) begin errors++; $display("FAIL reg_out after write %h: got %h expected %h", a, reg_out, model_vec()); end
  endtask
  task automatic axi_read(input logic [31:0] a, input int rhold);
    int cyc = 0;
    logic [31:0] exp_d;
    logic [1:0] exp_r = (ERR && !in_rng(a)) ? 2'b10 : 2'b00;
    arvalid = 1; araddr = a;
    while (!arready) begin
      if (cyc >= 50) begin
        checks++; errors++;
        $display("FAIL read_timeout addr=%h: arready not seen within 50 cycles", a);
        arvalid = 0;
        return;
      end
      tick(); cyc++;
    end
    exp_d = in_rng(a) ? model[idx_of(a)] : 32'h0;
    tick(); arvalid = 0;
    checks++;
    if (rvalid !== 1'b1 || rdata !== exp_d || rresp !== exp_r || arready !== 1'b0) begin
      errors++; $display("FAIL read addr=%h: got rvalid=%b rdata=%h rresp=%b arready=%b expected 1 %h %b 0", a, rvalid, rdata, rresp, arready, exp_d, exp_r);
    end
    for (int i = 0; i < rhold; i++) begin
      tick();
      checks++;
      if (rvalid !== 1'b1 || rdata !== exp_d || rresp !== exp_r || arready !== 1'b0) begin
        errors++; $display("FAIL r_hold addr=%h: got rvalid=%b rdata=%h rresp=%b arready=%b expected 1 %h %b 0", a, rvalid, rdata, rresp, arready, exp_d, exp_r);
      end
    end
    rready = 1; tick(); rready = 0;
    checks++;
    if (rvalid !== 1'b0) begin errors++; $display("FAIL rvalid_clear: got %b expected 0", rvalid); end
  endtask
  task automatic test_reset();
    rstn = 0;
    repeat (3) tick();
    clear_model();
    checks++;
    if ({awready, wready, arready, bvalid, rvalid, bresp, rresp} !== '0 || rdata !== '0 || wr_strobe !== '0) begin
      errors++; $display("FAIL reset_outputs: got aw=%b w=%b ar=%b b=%b r=%b bresp=%b rresp=%b rdata=%h strb=%h expected all 0", awready, wready, arready, bvalid, rvalid, bresp, rresp, rdata, wr_strobe);
    end
    checks++;
    if (reg_out !== model_vec()) begin errors++; $display("FAIL reset_reg_out: got %h expected %h", reg_out, model_vec()); end
    rstn = 1;
    tick();
    checks++;
    if ({awready, wready, arready} !== 3'b111) begin errors++; $display("FAIL ready_after_reset: got %b expected 111", {awready, wready, arready}); end
  endtask
  task automatic test_id_read();
    axi_read(BASE, 0);
  endtask
  task automatic test_same_cycle();
    axi_write(BASE + 32'h4, 32'hDEAD_BEEF, 0, 0, 0);
    axi_read(BASE + 32'h4, 0);
    checks++;
    if (reg_out[63:32] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL reg1_slot: got %h expected deadbeef", reg_out[63:32]); end
  endtask
  task automatic test_w_first();
    axi_write(BASE + 32'h8, 32'h1234_5678, 3, 0, 0);
    axi_read(BASE + 32'h8, 0);
  endtask
  task automatic test_aw_first();
    axi_write(BASE + 32'hC, $urandom, 0, 2, 0);
    axi_read(BASE + 32'hC, 0);
  endtask
  task automatic test_bready_hold();
    axi_write(BASE + 32'h4, $urandom, 0, 0, 5);
  endtask
  task automatic test_rready_hold();
    axi_write(BASE + 32'h3C, $urandom, 0, 0, 0);
    axi_read(BASE + 32'h3C, 4);
  endtask
  task automatic test_out_of_range();
    axi_write(BASE + 32'h40, $urandom, 0, 0, 1);
    axi_read(BASE + 32'h40, 1);
    axi_write(BASE, $urandom, 1, 0, 0);
    axi_read(BASE, 0);
    axi_write(BASE + 32'h8000_0000, $urandom, 0, 0, 0);
  endtask
  task automatic test_concurrent();
    axi_write(BASE + 32'h10, $urandom, 0, 0, 0);
    fork
      axi_write(BASE + 32'h10, $urandom, 0, 0, 0);
      axi_read(BASE + 32'h10, 0);
    join
    axi_read(BASE + 32'h10, 0);
  endtask
  task automatic test_random();
    for (int n = 0; n < 60; n++) begin
      logic [31:0] a = BASE + 32'($urandom_range(0, 19) * 4 + $urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) a = BASE + 32'h100 + 32'($urandom_range(0, 255));
      if ($urandom_range(0, 1) == 1)
        axi_write(a, $urandom, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
      else
        axi_read(a, $urandom_range(0, 3));
    end
  endtask
  task automatic test_reset_mid();
    awvalid = 1; awaddr = BASE + 32'h14;
    tick();
    awvalid = 0;
    rstn = 0; tick(); rstn = 1; tick();
    clear_model();
    wvalid = 1; wdata = 32'hA5A5_5A5A;
    tick();
    wvalid = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (bvalid !== 1'b0 || wr_strobe !== '0) begin errors++; $display("FAIL reset_mid: got bvalid=%b strobe=%h expected 0 0", bvalid, wr_strobe); end
    end
    checks++;
    if (reg_out !== model_vec()) begin errors++; $display("FAIL reset_mid_reg_out: got %h expected %h", reg_out, model_vec()); end
    rstn = 0; tick(); rstn = 1; tick();
    axi_write(BASE + 32'h14, 32'h0BAD_F00D, 0, 0, 0);
    axi_read(BASE + 32'h14, 0);
  endtask
  initial begin
    clear_model();
    #1;
    test_reset();
    test_id_read();
    test_same_cycle();
    test_w_first();
    test_aw_first();
    test_bready_hold();
    test_rready_hold();
    test_out_of_range();
    test_concurrent();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
